csel_adder_pipe: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor with valid/ready flow control.

---
 rtl/csel_pkg.sv | 14 +
 rtl/csel_adder_pipe_if.sv | 28 ++
 rtl/csel_block.sv | 22 ++
 rtl/csel_adder_pipe.sv | 124 ++++++++++++
 tb/tb_csel_adder_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csel_pkg.sv
// Shared helpers for the pipelined carry-select adder: stage count and
// the geometry check that WIDTH splits evenly into BLOCK*BPS-bit stages.
package csel_pkg;

  function automatic int nstages(int width, int block, int bps);
    return width / (block * bps);
  endfunction

  function automatic bit widths_ok(int width, int block, int bps);
    return (block > 0) && (bps > 0) && (width >= block * bps) &&
           ((width % (block * bps)) == 0);
  endfunction

endpackage

// File: rtl/csel_adder_pipe_if.sv
// Operand/result bus of the carry-select adder pipeline.
// Handshake: a word moves on a rising clk edge exactly when valid & ready are
// both high; a producer holds valid and its data stable until that edge.
interface csel_adder_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csel_block.sv
// One carry-select block: both carry hypotheses are summed in parallel and
// the real incoming carry picks the sum and the carry-out.
module csel_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             p
);
  logic [BLOCK:0] r0;
  logic [BLOCK:0] r1;

  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  assign s  = ci ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
  assign co = ci ? r1[BLOCK] : r0[BLOCK];
  assign p  = &(a ^ b);
endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: each stage resolves BLOCK*BPS bits
// and passes carry, finished low sum bits and the unprocessed operand bits on.
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BLOCK = 8,
  parameter int BPS   = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  csel_adder_pipe_if.slave                  bus,
  output logic [WIDTH/(BLOCK*BPS)-1:0]      dbg_stage_valid,
  output logic [WIDTH/BLOCK-1:0]            dbg_prop
);
  localparam int SW  = BLOCK * BPS;
  localparam int NST = nstages(WIDTH, BLOCK, BPS);

  if (!widths_ok(WIDTH, BLOCK, BPS)) begin : g_param_err
    $error("csel_adder_pipe: WIDTH must be a positive multiple of BLOCK*BPS");
  end

  logic [NST-1:0]   v;
  logic [NST:0]     rdy;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  // Subtraction is a + ~b + 1; cin only matters when adding.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign c_first = bus.sub | bus.cin;

  assign rdy[NST] = bus.out_ready;

  for (genvar k = 0; k < NST; k++) begin : stg
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic [WIDTH-LO-1:0] ra;
    logic [WIDTH-LO-1:0] rb;
    logic                cc;
    logic                vin;
    logic [HI-1:0]       s_next;
    logic [SW-1:0]       cs;
    logic [BPS:0]        bc;
    logic                v_q;
    logic                c_q;
    logic [HI-1:0]       s_q;

    if (k == 0) begin : g_src
      assign ra     = bus.a;
      assign rb     = b_eff;
      assign cc     = c_first;
      assign vin    = bus.in_valid;
      assign s_next = cs;
    end else begin : g_src
      assign ra     = {stg[k-1].g_rem.a_q};
      assign rb     = {stg[k-1].g_rem.b_q};
      assign cc     = stg[k-1].c_q;
      assign vin    = v[k-1];
      assign s_next = {cs, stg[k-1].s_q};
    end

    assign bc[0] = cc;
    for (genvar j = 0; j < BPS; j++) begin : blk
      csel_block #(.BLOCK(BLOCK)) u_blk (
        .a  (ra[j*BLOCK +: BLOCK]),
        .b  (rb[j*BLOCK +: BLOCK]),
        .ci (bc[j]),
        .s  (cs[j*BLOCK +: BLOCK]),
        .co (bc[j+1]),
        .p  (dbg_prop[k*BPS + j])
      );
    end

    // A stage may load whenever it is empty or its contents leave this edge.
    assign rdy[k] = !v_q | rdy[k+1];
    assign v[k]   = v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (rdy[k]) begin
        v_q <= vin;
        if (vin) begin
          c_q <= bc[BPS];
          s_q <= s_next;
        end
      end
    end

    if (k < NST - 1) begin : g_rem
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[k] && vin) begin
          a_q <= ra[WIDTH-LO-1:SW];
          b_q <= rb[WIDTH-LO-1:SW];
        end
      end
    end else begin : g_fin
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (rdy[k] && vin) begin
          ovf_q <= cs[SW-1] ^ ra[SW-1] ^ rb[SW-1] ^ bc[BPS];
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v[NST-1];
  assign bus.sum       = stg[NST-1].s_q;
  assign bus.cout      = stg[NST-1].c_q;
  assign bus.ovf       = stg[NST-1].g_fin.ovf_q;
  assign dbg_stage_valid = v;
endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: directed corner cases on the default build plus
// randomized streams on four parameter sets against an arithmetic model.
module tb_csel_adder_pipe;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int wdt[NI]     = '{64, 32, 64, 16};
  int exp_lat[NI] = '{4, 8, 1, 1};

  logic        drv_valid[NI], drv_cin[NI], drv_sub[NI], drv_oready[NI];
  logic [63:0] drv_a[NI], drv_b[NI];
  logic        obs_iready[NI], obs_valid[NI], obs_cout[NI], obs_ovf[NI];
  logic [63:0] obs_sum[NI];

  logic [3:0] dv0; logic [7:0] dv1; logic [0:0] dv2; logic [0:0] dv3;
  logic [7:0] dp0; logic [7:0] dp1; logic [3:0] dp2; logic [1:0] dp3;

  csel_adder_pipe_if #(.WIDTH(64)) if0 ();
  csel_adder_pipe_if #(.WIDTH(32)) if1 ();
  csel_adder_pipe_if #(.WIDTH(64)) if2 ();
  csel_adder_pipe_if #(.WIDTH(16)) if3 ();

  assign if0.in_valid = drv_valid[0]; assign if0.a = drv_a[0]; assign if0.b = drv_b[0];
  assign if0.cin = drv_cin[0]; assign if0.sub = drv_sub[0]; assign if0.out_ready = drv_oready[0];
  assign obs_iready[0] = if0.in_ready; assign obs_valid[0] = if0.out_valid;
  assign obs_sum[0] = if0.sum; assign obs_cout[0] = if0.cout; assign obs_ovf[0] = if0.ovf;

  assign if1.in_valid = drv_valid[1]; assign if1.a = drv_a[1][31:0]; assign if1.b = drv_b[1][31:0];
  assign if1.cin = drv_cin[1]; assign if1.sub = drv_sub[1]; assign if1.out_ready = drv_oready[1];
  assign obs_iready[1] = if1.in_ready; assign obs_valid[1] = if1.out_valid;
  assign obs_sum[1] = {32'd0, if1.sum}; assign obs_cout[1] = if1.cout; assign obs_ovf[1] = if1.ovf;

  assign if2.in_valid = drv_valid[2]; assign if2.a = drv_a[2]; assign if2.b = drv_b[2];
  assign if2.cin = drv_cin[2]; assign if2.sub = drv_sub[2]; assign if2.out_ready = drv_oready[2];
  assign obs_iready[2] = if2.in_ready; assign obs_valid[2] = if2.out_valid;
  assign obs_sum[2] = if2.sum; assign obs_cout[2] = if2.cout; assign obs_ovf[2] = if2.ovf;

  assign if3.in_valid = drv_valid[3]; assign if3.a = drv_a[3][15:0]; assign if3.b = drv_b[3][15:0];
  assign if3.cin = drv_cin[3]; assign if3.sub = drv_sub[3]; assign if3.out_ready = drv_oready[3];
  assign obs_iready[3] = if3.in_ready; assign obs_valid[3] = if3.out_valid;
  assign obs_sum[3] = {48'd0, if3.sum}; assign obs_cout[3] = if3.cout; assign obs_ovf[3] = if3.ovf;

  csel_adder_pipe #(.WIDTH(64), .BLOCK(8),  .BPS(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .dbg_stage_valid(dv0), .dbg_prop(dp0));
  csel_adder_pipe #(.WIDTH(32), .BLOCK(4),  .BPS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .dbg_stage_valid(dv1), .dbg_prop(dp1));
  csel_adder_pipe #(.WIDTH(64), .BLOCK(16), .BPS(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .dbg_stage_valid(dv2), .dbg_prop(dp2));
  csel_adder_pipe #(.WIDTH(16), .BLOCK(8),  .BPS(2)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3), .dbg_stage_valid(dv3), .dbg_prop(dp3));

  // Reference: plain modular arithmetic; result packed as {ovf, cout, sum}.
  function automatic logic [65:0] ref_res(int w, logic [63:0] a_in, logic [63:0] b_in, logic cin, logic sub);
    logic [64:0] full;
    logic [63:0] mask, a, b, s;
    logic co, ov, sa, sb, ss;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    sa = a[w-1];
    sb = b[w-1];
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      co = (a >= b);
    end else begin
      full = {1'b0, a} + {1'b0, b} + 65'(cin);
      co = full[w];
    end
    s = full[63:0] & mask;
    ss = s[w-1];
    ov = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    return {ov, co, s};
  endfunction

  function automatic logic [63:0] rnd_op(int w);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return mask;
      2: return 64'd1 << (w - 1);
      3: return mask >> 1;
      default: return {$urandom(), $urandom()} & mask;
    endcase
  endfunction

  task automatic set_in(input int i, input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub);
    drv_valid[i] = v; drv_a[i] = a; drv_b[i] = b; drv_cin[i] = cin; drv_sub[i] = sub;
  endtask

  // Sends one operand set into an idle pipe and waits for its result.
  task automatic do_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub, output logic [63:0] s, output logic co, output logic ov,
                       output int lat);
    int n;
    s = '0; co = 1'b0; ov = 1'b0; lat = -1; n = 0;
    drv_oready[i] = 1'b1;
    set_in(i, 1'b1, a, b, cin, sub);
    @(negedge clk);
    while (!obs_iready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    drv_valid[i] = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (obs_valid[i]) begin
        s = obs_sum[i]; co = obs_cout[i]; ov = obs_ovf[i]; lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int stale;
    for (int i = 0; i < NI; i++) begin
      drv_oready[i] = 1'b1;
      set_in(i, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({obs_valid[i], obs_cout[i], obs_ovf[i], obs_sum[i]} !== 67'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: valid=%b sum=%h cout=%b ovf=%b, want all 0",
                 i, obs_valid[i], obs_sum[i], obs_cout[i], obs_ovf[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_iready[i] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready dut%0d: got %b want 1", i, obs_iready[i]);
      end
    end
    // Three results in flight, output stalled, then reset mid-stream.
    drv_oready[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_in(0, 1'b1, rnd_op(64), rnd_op(64), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
    end
    drv_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dv0 !== 4'b1110 || obs_valid[0] !== 1'b1) begin
      errors++; $display("FAIL inflight: stages=%b out_valid=%b want 1110/1", dv0, obs_valid[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_valid[0] !== 1'b0 || obs_sum[0] !== 64'd0 || obs_cout[0] !== 1'b0 || obs_ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out: valid=%b sum=%h cout=%b ovf=%b want 0", obs_valid[0], obs_sum[0],
               obs_cout[0], obs_ovf[0]);
    end
    checks++;
    if (dv0 !== 4'b0000) begin
      errors++; $display("FAIL midreset_stages: got %b want 0000", dv0);
    end
    @(negedge clk); rst_n = 1'b1; drv_oready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_iready[0] !== 1'b1) begin
      errors++; $display("FAIL midreset_in_ready: got %b want 1", obs_iready[0]);
    end
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (obs_valid[0] !== 1'b0) stale++;
      @(posedge clk); #1;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL stale_output: %0d cycles with out_valid, want 0", stale);
    end
  endtask

  task automatic test_carry();
    logic [63:0] s; logic co, ov; int lat;
    do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {64'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL carry_ripple: sum=%h cout=%b ovf=%b want 0/1/0", s, co, ov);
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL carry_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_sub();
    logic [63:0] s; logic co, ov; int lat;
    do_op(0, 64'd5, 64'd7, 1'b1, 1'b1, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b want fffffffffffffffe/0/0", s, co, ov);
    end
    do_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b want 7fffffffffffffff/1/1", s, co, ov);
    end
  endtask

  task automatic test_ovf();
    logic [63:0] s; logic co, ov; int lat;
    do_op(0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_ovf: sum=%h cout=%b ovf=%b want 8000000000000000/0/1", s, co, ov);
    end
  endtask

  task automatic test_latency();
    logic [63:0] a, b, s; logic co, ov, cin, sub; int lat; logic [65:0] e;
    for (int i = 0; i < NI; i++) begin
      a = rnd_op(wdt[i]); b = rnd_op(wdt[i]);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      e = ref_res(wdt[i], a, b, cin, sub);
      do_op(i, a, b, cin, sub, s, co, ov, lat);
      checks++;
      if (lat != exp_lat[i] || {ov, co, s} !== e) begin
        errors++;
        $display("FAIL latency dut%0d: lat=%0d res=%h want lat=%0d res=%h", i, lat, {ov, co, s}, exp_lat[i], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [65:0] exp_q[$];
    logic [65:0] e;
    logic acc;
    int sent, got, cyc, last, gap_bad, blocked;
    sent = 0; got = 0; cyc = 0; last = -1; gap_bad = 0; blocked = 0; acc = 1'b0;
    drv_oready[0] = 1'b1;
    while (got < 8 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (acc) begin drv_valid[0] = 1'b0; acc = 1'b0; end
      if (!drv_valid[0] && sent < 8)
        set_in(0, 1'b1, rnd_op(64), rnd_op(64), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (obs_valid[0]) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 66'bx;
        if ({obs_ovf[0], obs_cout[0], obs_sum[0]} !== e) begin
          errors++; $display("FAIL b2b_result %0d: got %h want %h", got, {obs_ovf[0], obs_cout[0], obs_sum[0]}, e);
        end
        if (last >= 0 && cyc - last != 1) gap_bad++;
        last = cyc; got++;
      end
      if (drv_valid[0]) begin
        if (obs_iready[0]) begin
          exp_q.push_back(ref_res(64, drv_a[0], drv_b[0], drv_cin[0], drv_sub[0]));
          sent++; acc = 1'b1;
        end else blocked++;
      end
    end
    drv_valid[0] = 1'b0;
    checks++;
    if (got != 8 || gap_bad != 0 || blocked != 0) begin
      errors++; $display("FAIL b2b_throughput: got=%0d gaps=%0d blocked=%0d want 8/0/0", got, gap_bad, blocked);
    end
  endtask

  task automatic test_backpressure();
    logic [65:0] exp_q[$];
    logic [65:0] e;
    logic [63:0] held;
    logic acc, stalled;
    int sent, got, cyc, blocked, unstable;
    sent = 0; got = 0; cyc = 0; blocked = 0; unstable = 0; acc = 1'b0; stalled = 1'b0; held = '0;
    while (got < 10 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (acc) begin drv_valid[0] = 1'b0; acc = 1'b0; end
      if (!drv_valid[0] && sent < 10)
        set_in(0, 1'b1, rnd_op(64), rnd_op(64), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drv_oready[0] = !(cyc >= 3 && cyc <= 8);
      @(negedge clk);
      if (stalled && obs_valid[0] && obs_sum[0] !== held) unstable++;
      stalled = obs_valid[0] && !drv_oready[0];
      held = obs_sum[0];
      if (obs_valid[0] && drv_oready[0]) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 66'bx;
        if ({obs_ovf[0], obs_cout[0], obs_sum[0]} !== e) begin
          errors++; $display("FAIL bp_result %0d: got %h want %h", got, {obs_ovf[0], obs_cout[0], obs_sum[0]}, e);
        end
        got++;
      end
      if (drv_valid[0]) begin
        if (obs_iready[0]) begin
          exp_q.push_back(ref_res(64, drv_a[0], drv_b[0], drv_cin[0], drv_sub[0]));
          sent++; acc = 1'b1;
        end else blocked++;
      end
    end
    drv_valid[0] = 1'b0; drv_oready[0] = 1'b1;
    checks++;
    if (blocked == 0) begin
      errors++; $display("FAIL bp_in_ready: never dropped while stalled, blocked=%0d want >0", blocked);
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL bp_hold: held sum changed %0d times, want 0", unstable);
    end
    checks++;
    if (got != 10 || sent != 10 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count: got=%0d sent=%0d left=%0d want 10/10/0", got, sent, exp_q.size());
    end
  endtask

  task automatic test_sweep(input int i, input int nops);
    logic [65:0] exp_q[$];
    logic [65:0] e;
    logic acc;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; acc = 1'b0;
    drv_valid[i] = 1'b0;
    while (got < nops && cyc < nops * 20) begin
      @(posedge clk); #1; cyc++;
      if (acc) begin drv_valid[i] = 1'b0; acc = 1'b0; end
      if (!drv_valid[i] && sent < nops && $urandom_range(0, 3) != 0)
        set_in(i, 1'b1, rnd_op(wdt[i]), rnd_op(wdt[i]), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drv_oready[i] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (obs_valid[i] && drv_oready[i]) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 66'bx;
        if ({obs_ovf[i], obs_cout[i], obs_sum[i]} !== e) begin
          errors++;
          $display("FAIL sweep_dut%0d result %0d: got %h want %h", i, got, {obs_ovf[i], obs_cout[i], obs_sum[i]}, e);
        end
        got++;
      end
      if (drv_valid[i] && obs_iready[i]) begin
        exp_q.push_back(ref_res(wdt[i], drv_a[i], drv_b[i], drv_cin[i], drv_sub[i]));
        sent++; acc = 1'b1;
      end
    end
    drv_valid[i] = 1'b0; drv_oready[i] = 1'b1;
    checks++;
    if (got != nops || exp_q.size() != 0) begin
      errors++; $display("FAIL sweep_dut%0d count: got=%0d left=%0d want %0d/0", i, got, exp_q.size(), nops);
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_sub();
    test_ovf();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_sweep(1, 1000);
    test_sweep(2, 1000);
    test_sweep(3, 1000);
    test_sweep(0, 300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
